// File: rtl/edge_stamp_pkg.sv
// Shared types and defaults for the edge timestamp generator.
// Timestamps are unsigned 6.10 fixed point.
package edge_stamp_pkg;

    localparam int W_DEF     = 16;
    localparam int PRIME_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_RUN,
        S_ERR
    } state_t;

endpackage

// File: rtl/edge_stamp_gen_mod_add.sv
// Modular add: (a + b) mod p, valid for a < p and b < p.
// One extra sum bit and a single conditional subtract.
module mod_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic [W-1:0] y
);

    logic [W:0] sum;
    logic [W:0] p_ext;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign p_ext = {1'b0, p};

    // A sum equal to p folds to zero, so p itself never appears.
    assign y = (sum >= p_ext) ? W'(sum - p_ext) : sum[W-1:0];

endmodule

// File: rtl/edge_stamp_gen.sv
// Two-lane fractional edge timestamp generator.
// Lanes advance by step modulo P; lane 2 is phase-shifted by offset2.
module edge_stamp_gen
    import edge_stamp_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int PRIME_CYCLES = PRIME_DEF
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] eff_period,
    input  logic [W-1:0] step,
    input  logic [W-1:0] offset2,
    output logic [W-1:0] edges1,
    output logic [W-1:0] edges2,
    output logic         rst_cnt,
    output logic         valid,
    output logic         busy,
    output logic         err
);

    localparam int CW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
    localparam logic [CW-1:0] PC_LAST =
        CW'((PRIME_CYCLES > 0) ? PRIME_CYCLES - 1 : 0);

    state_t        state;
    logic [W-1:0]  per_q;
    logic [W-1:0]  step_q;
    logic [W-1:0]  off_q;
    logic [W-1:0]  nxt1;
    logic [W-1:0]  nxt2;
    logic [CW-1:0] pcnt;
    logic          cfg_bad;

    mod_add #(.W(W)) u_lane1 (
        .a (edges1),
        .b (step_q),
        .p (per_q),
        .y (nxt1)
    );

    mod_add #(.W(W)) u_lane2 (
        .a (edges2),
        .b (step_q),
        .p (per_q),
        .y (nxt2)
    );

    assign cfg_bad = (per_q == '0) || (step_q >= per_q) ||
                     (off_q >= per_q);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state  <= S_IDLE;
            edges1 <= '0;
            edges2 <= '0;
            per_q  <= '0;
            step_q <= '0;
            off_q  <= '0;
            pcnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        per_q  <= eff_period;
                        step_q <= step;
                        off_q  <= offset2;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (cfg_bad) begin
                        state <= S_ERR;
                    end else begin
                        edges1 <= '0;
                        edges2 <= off_q;
                        pcnt   <= '0;
                        state  <= (PRIME_CYCLES == 0) ? S_RUN : S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        edges1 <= nxt1;
                        edges2 <= nxt2;
                        if (pcnt == PC_LAST) begin
                            state <= S_RUN;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        edges1 <= nxt1;
                        edges2 <= nxt2;
                    end
                end
                S_ERR: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state register.
    assign rst_cnt = (state == S_LOAD);
    assign valid   = (state == S_RUN);
    assign busy    = (state != S_IDLE);
    assign err     = (state == S_ERR);

endmodule

// File: tb/tb_edge_stamp_gen.sv
// Scoreboard bench for edge_stamp_gen.
// Stimulus queues expected valid edges; a monitor checks them.
module tb_edge_stamp_gen;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start;
    logic        stop;
    logic [15:0] eff_period;
    logic [15:0] step;
    logic [15:0] offset2;
    logic [15:0] edges1;
    logic [15:0] edges2;
    logic        rst_cnt;
    logic        valid;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [31:0] sb_q[$];
    logic [31:0] got;
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    edge_stamp_gen #(.W(16), .PRIME_CYCLES(2)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start      (start),
        .stop       (stop),
        .eff_period (eff_period),
        .step       (step),
        .offset2    (offset2),
        .edges1     (edges1),
        .edges2     (edges2),
        .rst_cnt    (rst_cnt),
        .valid      (valid),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            tests++;
            got = {edges1, edges2};
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h expected none", got);
            end else begin
                exp_v = sb_q.pop_front();
                if (got !== exp_v) begin
                    fails++;
                    $display("FAIL sb_edges: got %h expected %h", got, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] e1, input logic [15:0] e2);
        sb_q.push_back({e1, e2});
    endtask

    // Start a run and check LOAD and both PRIME cycles; ends in RUN #1.
    task automatic begin_run(input logic [15:0] p, input logic [15:0] s,
                             input logic [15:0] o,
                             input logic [31:0] pr1, input logic [31:0] pr2);
        eff_period = p;
        step       = s;
        offset2    = o;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("load_rst_cnt", {31'd0, rst_cnt}, 32'd1);
        chk("load_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("prime1_edges", {edges1, edges2}, pr1);
        chk("prime1_flags", {29'd0, rst_cnt, valid, busy}, 32'b001);
        tick();
        chk("prime2_edges", {edges1, edges2}, pr2);
        chk("prime2_valid", {31'd0, valid}, 32'd0);
        tick();
    endtask

    task automatic end_run(input logic [31:0] held);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_flags", {29'd0, valid, busy, err}, 32'b000);
        chk("stop_hold", {edges1, edges2}, held);
    endtask

    initial begin
        rst_l      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        eff_period = '0;
        step       = '0;
        offset2    = '0;
        tick();
        tick();
        chk("reset_outs",
            {edges1, edges2} | {28'd0, rst_cnt, valid, busy, err}, 32'd0);
        rst_l = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Basic run, lane 2 offset by half a period.
        push(16'h0C00, 16'h0400);
        push(16'h0200, 16'h0A00);
        push(16'h0800, 16'h0000);
        begin_run(16'h1000, 16'h0600, 16'h0800,
                  {16'h0000, 16'h0800}, {16'h0600, 16'h0E00});
        tick();
        tick();
        end_run({16'h0800, 16'h0000});

        // step == P is rejected after the LOAD pulse.
        eff_period = 16'h1000;
        step       = 16'h1000;
        offset2    = 16'h0000;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("err_load_pulse", {31'd0, rst_cnt}, 32'd1);
        tick();
        chk("err_flags", {28'd0, rst_cnt, valid, busy, err}, 32'b0011);
        tick();
        chk("err_sticky", {30'd0, valid, err}, 32'b01);
        chk("err_hold", {edges1, edges2}, {16'h0800, 16'h0000});
        end_run({16'h0800, 16'h0000});

        // Exact wrap: a sum equal to P must read as zero.
        push(16'h0000, 16'h0000);
        push(16'h0800, 16'h0800);
        push(16'h0000, 16'h0000);
        begin_run(16'h1000, 16'h0800, 16'h0000,
                  {16'h0000, 16'h0000}, {16'h0800, 16'h0800});
        tick();
        tick();
        end_run({16'h0000, 16'h0000});

        // start and stop together: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("both_flags", {30'd0, busy, rst_cnt}, 32'd0);

        // Reset in RUN beats start; no LOAD pulse follows.
        push(16'h0C00, 16'h0400);
        begin_run(16'h1000, 16'h0600, 16'h0800,
                  {16'h0000, 16'h0800}, {16'h0600, 16'h0E00});
        rst_l = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        rst_l = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        chk("midrst_outs",
            {edges1, edges2} | {28'd0, rst_cnt, valid, busy, err}, 32'd0);
        tick();
        chk("midrst_idle", {30'd0, busy, rst_cnt}, 32'd0);

        // Inputs changed mid-run are ignored until the next start.
        push(16'h0C00, 16'h0400);
        push(16'h0200, 16'h0A00);
        push(16'h0800, 16'h0000);
        eff_period = 16'h1000;
        step       = 16'h0600;
        offset2    = 16'h0800;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        eff_period = 16'h0C00;
        step       = 16'h0100;
        offset2    = 16'h0300;
        chk("chg_load", {31'd0, rst_cnt}, 32'd1);
        tick();
        chk("chg_prime1", {edges1, edges2}, {16'h0000, 16'h0800});
        tick();
        chk("chg_prime2", {edges1, edges2}, {16'h0600, 16'h0E00});
        tick();
        tick();
        tick();
        end_run({16'h0800, 16'h0000});

        // New P = 0xC00 after restart.
        push(16'h0000, 16'h0800);
        push(16'h0600, 16'h0200);
        push(16'h0000, 16'h0800);
        begin_run(16'h0C00, 16'h0600, 16'h0800,
                  {16'h0000, 16'h0800}, {16'h0600, 16'h0200});
        tick();
        tick();
        end_run({16'h0000, 16'h0800});

        tick();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
